// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a UART transmitter block.
// Enforces an inter-frame gap and aborts frames that never report tx_end.
module uart_tx_arbiter #(
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200
) (
  input  logic       clk16,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic [7:0] paral_data,
  output logic       tx_en,
  input  logic       tx_end,
  output logic       grant_id,
  output logic       busy,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam int unsigned CNT_MAX  = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 2);
  // Abort on the edge that completes TIMEOUT_CYCLES cycles of SEND.
  localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t             state, state_d;
  logic               ptr, ptr_d;
  logic [CNT_W-1:0]   tmo_cnt, tmo_cnt_d;
  logic [CNT_W-1:0]   gap_cnt, gap_cnt_d;
  logic [7:0]         paral_data_d;
  logic               tx_en_d, grant_id_d, busy_d, timeout_err_d;
  logic               ack0_d, ack1_d;
  logic               tmo_set;
  logic               win;

  // State and registered outputs.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      paral_data  <= 8'h00;
      tx_en       <= 1'b0;
      grant_id    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      tmo_cnt     <= tmo_cnt_d;
      gap_cnt     <= gap_cnt_d;
      paral_data  <= paral_data_d;
      tx_en       <= tx_en_d;
      grant_id    <= grant_id_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
      ack0        <= ack0_d;
      ack1        <= ack1_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state;
    ptr_d        = ptr;
    tmo_cnt_d    = tmo_cnt;
    gap_cnt_d    = gap_cnt;
    paral_data_d = paral_data;
    tx_en_d      = tx_en;
    grant_id_d   = grant_id;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    tmo_set      = 1'b0;
    win          = 1'b0;

    case (state)
      IDLE: begin
        tx_en_d = 1'b0;
        if (req0 || req1) begin
          win          = (req0 && req1) ? ptr : req1;
          grant_id_d   = win;
          paral_data_d = win ? data1 : data0;
          ack0_d       = ~win;
          ack1_d       = win;
          ptr_d        = ~win;
          tmo_cnt_d    = '0;
          tx_en_d      = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        if (tx_end) begin
          tx_en_d   = 1'b0;
          gap_cnt_d = CNT_W'(GAP_CYCLES);
          state_d   = GAP;
        end else if (tmo_cnt >= CNT_W'(TMO_LAST)) begin
          tx_en_d   = 1'b0;
          tmo_set   = 1'b1;
          gap_cnt_d = CNT_W'(GAP_CYCLES);
          state_d   = GAP;
        end else if (tmo_cnt != CNT_W'(CNT_MAX)) begin
          tmo_cnt_d = tmo_cnt + CNT_W'(1);
        end
      end
      GAP: begin
        // A loaded value of 0 or 1 both give a single GAP cycle.
        tx_en_d = 1'b0;
        if (gap_cnt <= CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (tmo_set) begin
      timeout_err_d = 1'b1;
    end else if (err_clr) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err;
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 16, is the number of idle clk16 cycles forced between frames (16 = one bit time).
REQ-002 Parameter TIMEOUT_CYCLES, default 200, is the maximum number of clk16 cycles allowed in SEND before the frame is aborted.
REQ-003 Clock and reset: one clock, clk16; reset rst_n is asynchronous and active-low.
REQ-004 clk16  input  1  system and UART 16x oversample clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req0  input  1  requester 0 has a byte pending; held high until ack0.
REQ-007 data0  input  8  requester 0 byte; stable while req0 is high.
REQ-008 ack0  output  1  one-cycle pulse: data0 captured.
REQ-009 req1  input  1  requester 1 has a byte pending.
REQ-010 data1  input  8  requester 1 byte.
REQ-011 ack1  output  1  one-cycle pulse: data1 captured.
REQ-012 paral_data  output  8  byte to txblock; registered.
REQ-013 tx_en  output  1  txblock enable; level, high for the whole frame.
REQ-014 tx_end  input  1  txblock end-of-frame pulse after the stop bit.
REQ-015 grant_id  output  1  requester that owns the current or last frame.
REQ-016 busy  output  1  high whenever state is not IDLE.
REQ-017 timeout_err  output  1  sticky: a frame was aborted by timeout.
REQ-018 err_clr  input  1  synchronous clear of timeout_err.

Function
REQ-019 FSM states: IDLE, SEND, GAP; all outputs registered.
REQ-020 IDLE, no request pending: stay in IDLE, tx_en=0.
REQ-021 IDLE, at least one reqN high at an edge, same edge:
- latch that dataN into paral_data
- set grant_id=N, set tx_en=1
- pulse ackN high for exactly one cycle
- clear the timeout counter and enter SEND
REQ-022 Arbitration is round-robin via pointer ptr:
- both requests high: requester ptr wins
- one request high: that requester wins
- after any grant, ptr becomes the non-granted requester
REQ-023 Requests are ignored outside IDLE; at most one ack is high per cycle.
REQ-024 SEND: tx_en stays 1 and paral_data stays constant; the timeout counter increments each cycle.
REQ-025 SEND, tx_end=1: next edge tx_en=0, load the gap counter, enter GAP.
REQ-026 SEND, counter reaches TIMEOUT_CYCLES with tx_end=0: next edge tx_en=0, timeout_err=1, enter GAP.
REQ-027 tx_end and timeout in the same cycle: tx_end wins and timeout_err is not set.
REQ-028 GAP: tx_en=0 for GAP_CYCLES cycles, then IDLE.
REQ-029 GAP_CYCLES=0: GAP lasts one cycle, so tx_en is always low for at least one cycle between frames.
REQ-030 tx_end in IDLE or GAP is ignored.
REQ-031 err_clr=1 clears timeout_err; a set in the same cycle wins.
REQ-032 Counters are sized to hold max(GAP_CYCLES, TIMEOUT_CYCLES) and saturate; they do not wrap.
REQ-033 busy is 0 in IDLE and 1 in SEND and GAP.

Reset
REQ-034 On rst_n=0, asynchronously:
- state=IDLE, ptr=0
- tx_en=0, paral_data=8'h00
- ack0=ack1=0, grant_id=0
- busy=0, timeout_err=0
- both counters=0
REQ-035 Reset mid-frame drops tx_en immediately; the in-flight byte is discarded with no ack reissued.
REQ-036 After rst_n releases, the first arbitration is at the first rising clk16 edge.

Verification
REQ-037 Single request: req0=1 with data0=8'b1000_1110 -> same edge paral_data=8'h8E, tx_en=1; ack0 high one cycle; grant_id=0.
REQ-038 Frame completion: tx_end pulsed 160 cycles into SEND -> next edge tx_en=0; busy low after exactly 16 more cycles.
REQ-039 Contention: req0=req1=1 continuously -> grants alternate 0,1,0,1; each ack is a single pulse.
REQ-040 Timeout: no tx_end -> tx_en drops after 200 SEND cycles; timeout_err=1 until err_clr; a tx_end pulse in the same cycle as err_clr leaves timeout_err=0.
REQ-041 Reset mid-frame: rst_n=0 about 80 cycles into SEND -> tx_en=0 and paral_data=8'h00 with no clock edge.
REQ-042 Reset mid-frame, continued: after release with req1=1, requester 1 is granted first.
